// File: rtl/max3421_reg_arbiter.sv
// Round-robin arbiter sharing one MAX3421 SPI engine among NUM_REQ register requesters.
// Optional watchdog on the engine handshake: define MAX3421_ARB_TIMEOUT_EN.
module max3421_reg_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk_in,
  input  logic                 n_rst_in,
  input  logic [NUM_REQ-1:0]   req_valid_in,
  input  logic [5*NUM_REQ-1:0] req_reg_in,
  input  logic [NUM_REQ-1:0]   req_write_in,
  input  logic [8*NUM_REQ-1:0] req_data_in,
  output logic [NUM_REQ-1:0]   req_ready_out,
  output logic [NUM_REQ-1:0]   rsp_valid_out,
  output logic [7:0]           rsp_status_out,
  output logic [7:0]           rsp_data_out,
  output logic                 rsp_err_out,
  output logic [7:0]           spi_byte0_out,
  output logic [7:0]           spi_byte1_out,
  output logic [6:0]           spi_count_out,
  output logic                 spi_valid_out,
  input  logic [7:0]           spi_byte0_in,
  input  logic [7:0]           spi_byte1_in,
  input  logic                 spi_finished_in
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] rr_ptr, gnt_idx, pick_idx;
  logic          pick_found;
  logic          cap_fin, cap_to;
  int            cand;
  int            pi;

  assign spi_count_out = 7'd2;
  assign cap_fin       = (state == WAIT) && spi_finished_in;
  assign pi            = int'(pick_idx);

  // Round-robin search starting at rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && req_valid_in[cand]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(cand);
      end
    end
  end

`ifdef MAX3421_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Finished wins a tie with the watchdog expiring in the same cycle.
  assign cap_to = (state == WAIT) && !spi_finished_in &&
                  (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in)             wd_cnt <= '0;
    else if (state == ISSUE)   wd_cnt <= '0;
    else if (state == WAIT)    wd_cnt <= wd_cnt + 16'd1;
  end

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in)    rsp_err_out <= 1'b0;
    else if (cap_fin) rsp_err_out <= 1'b0;
    else if (cap_to)  rsp_err_out <= 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign cap_to         = 1'b0;
  assign rsp_err_out    = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cap_fin || cap_to) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_out = '0;
    rsp_valid_out = '0;
    spi_valid_out = 1'b0;
    case (state)
      ISSUE: begin
        req_ready_out[gnt_idx] = 1'b1;
        spi_valid_out          = 1'b1;
      end
      RESP:    rsp_valid_out[gnt_idx] = 1'b1;
      default: ;
    endcase
  end

  // Frame is latched on the IDLE->ISSUE edge so it is stable for the whole valid pulse and WAIT.
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      gnt_idx        <= '0;
      rr_ptr         <= '0;
      spi_byte0_out  <= 8'h00;
      spi_byte1_out  <= 8'h00;
      rsp_status_out <= 8'h00;
      rsp_data_out   <= 8'h00;
    end else begin
      if (state == IDLE && pick_found) begin
        gnt_idx       <= pick_idx;
        spi_byte0_out <= {req_reg_in[5*pi +: 5], 1'b0, req_write_in[pi], 1'b0};
        spi_byte1_out <= req_write_in[pi] ? req_data_in[8*pi +: 8] : 8'h00;
      end
      if (state == ISSUE)
        rr_ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
      if (cap_fin) begin
        rsp_status_out <= spi_byte0_in;
        rsp_data_out   <= spi_byte1_in;
      end else if (cap_to) begin
        rsp_status_out <= 8'hFF;
        rsp_data_out   <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_max3421_reg_arbiter.sv
// Directed bench for max3421_reg_arbiter (NUM_REQ=2) with a hand-driven SPI engine model.
module tb_max3421_reg_arbiter;

  logic        clk_in = 1'b0;
  logic        n_rst_in;
  logic [1:0]  req_valid_in;
  logic [9:0]  req_reg_in;
  logic [1:0]  req_write_in;
  logic [15:0] req_data_in;
  logic [1:0]  req_ready_out, rsp_valid_out;
  logic [7:0]  rsp_status_out, rsp_data_out;
  logic        rsp_err_out;
  logic [7:0]  spi_byte0_out, spi_byte1_out;
  logic [6:0]  spi_count_out;
  logic        spi_valid_out;
  logic [7:0]  spi_byte0_in, spi_byte1_in;
  logic        spi_finished_in;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  max3421_reg_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_in(clk_in), .n_rst_in(n_rst_in),
    .req_valid_in(req_valid_in), .req_reg_in(req_reg_in),
    .req_write_in(req_write_in), .req_data_in(req_data_in),
    .req_ready_out(req_ready_out), .rsp_valid_out(rsp_valid_out),
    .rsp_status_out(rsp_status_out), .rsp_data_out(rsp_data_out),
    .rsp_err_out(rsp_err_out),
    .spi_byte0_out(spi_byte0_out), .spi_byte1_out(spi_byte1_out),
    .spi_count_out(spi_count_out), .spi_valid_out(spi_valid_out),
    .spi_byte0_in(spi_byte0_in), .spi_byte1_in(spi_byte1_in),
    .spi_finished_in(spi_finished_in)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (req_ready_out == 2'b00 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    chk({tag, "_grant_seen"}, 32'(n < 20), 32'd1);
  endtask

  // Grant, frame, single spi_valid pulse, engine completion and response.
  task automatic run_txn(input string tag, input logic [1:0] exp_gnt,
                         input logic [7:0] exp_b0, input logic [7:0] exp_b1,
                         input logic [7:0] st, input logic [7:0] dt,
                         input int eng_cycles, input bit drop);
    wait_grant(tag);
    chk({tag, "_gnt"},   32'(req_ready_out), 32'(exp_gnt));
    chk({tag, "_b0"},    32'(spi_byte0_out), 32'(exp_b0));
    chk({tag, "_b1"},    32'(spi_byte1_out), 32'(exp_b1));
    chk({tag, "_svld"},  32'(spi_valid_out), 32'd1);
    chk({tag, "_count"}, 32'(spi_count_out), 32'd2);
    if (drop) req_valid_in = req_valid_in & ~exp_gnt;
    @(negedge clk_in);
    chk({tag, "_svld_pulse"}, 32'(spi_valid_out), 32'd0);
    chk({tag, "_rdy_pulse"},  32'(req_ready_out), 32'd0);
    repeat (eng_cycles) @(negedge clk_in);
    chk({tag, "_b0_hold"}, 32'(spi_byte0_out), 32'(exp_b0));
    chk({tag, "_early_rsp"}, 32'(rsp_valid_out), 32'd0);
    spi_byte0_in = st; spi_byte1_in = dt; spi_finished_in = 1'b1;
    @(negedge clk_in);
    spi_finished_in = 1'b0;
    chk({tag, "_rvld"},   32'(rsp_valid_out),  32'(exp_gnt));
    chk({tag, "_status"}, 32'(rsp_status_out), 32'(st));
    chk({tag, "_data"},   32'(rsp_data_out),   32'(dt));
    chk({tag, "_err"},    32'(rsp_err_out),    32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_rst_in = 1'b0;
    req_valid_in = '0; req_reg_in = '0; req_write_in = '0; req_data_in = '0;
    spi_byte0_in = '0; spi_byte1_in = '0; spi_finished_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst_ready",  32'(req_ready_out),  32'd0);
    chk("rst_rvld",   32'(rsp_valid_out),  32'd0);
    chk("rst_svld",   32'(spi_valid_out),  32'd0);
    chk("rst_err",    32'(rsp_err_out),    32'd0);
    chk("rst_status", 32'(rsp_status_out), 32'd0);
    chk("rst_data",   32'(rsp_data_out),   32'd0);
    chk("rst_b0",     32'(spi_byte0_out),  32'd0);
    chk("rst_b1",     32'(spi_byte1_out),  32'd0);
    n_rst_in = 1'b1;
    @(negedge clk_in);

    // Single read by req0 of reg 18; req1 payload is a write of reg 17 with A5.
    req_reg_in   = {5'd17, 5'd18};
    req_write_in = 2'b10;
    req_data_in  = {8'hA5, 8'h33};
    req_valid_in = 2'b01;
    run_txn("rd0", 2'b01, 8'h90, 8'h00, 8'h41, 8'h0C, 3, 1'b1);
    @(negedge clk_in);
    chk("rd0_rvld_pulse", 32'(rsp_valid_out), 32'd0);
    chk("rd0_hold",       32'(rsp_status_out), 32'h41);

    req_valid_in = 2'b10;
    run_txn("wr1", 2'b10, 8'h8A, 8'hA5, 8'h05, 8'h77, 2, 1'b1);

    // Both held high: strict alternation starting from req0.
    req_valid_in = 2'b11;
    run_txn("rr_a", 2'b01, 8'h90, 8'h00, 8'h11, 8'h21, 1, 1'b0);
    run_txn("rr_b", 2'b10, 8'h8A, 8'hA5, 8'h12, 8'h22, 1, 1'b0);
    run_txn("rr_c", 2'b01, 8'h90, 8'h00, 8'h13, 8'h23, 1, 1'b0);
    run_txn("rr_d", 2'b10, 8'h8A, 8'hA5, 8'h14, 8'h24, 1, 1'b0);
    req_valid_in = 2'b00;
    repeat (3) @(negedge clk_in);

    // Stray finished while idle must not produce a response or overwrite rsp_*.
    spi_byte0_in = 8'hEE; spi_byte1_in = 8'hEE; spi_finished_in = 1'b1;
    @(negedge clk_in);
    spi_finished_in = 1'b0;
    chk("stray_rvld",   32'(rsp_valid_out),  32'd0);
    @(negedge clk_in);
    chk("stray_rvld2",  32'(rsp_valid_out),  32'd0);
    chk("stray_status", 32'(rsp_status_out), 32'h14);
    req_valid_in = 2'b01;
    run_txn("post_stray", 2'b01, 8'h90, 8'h00, 8'h42, 8'h0D, 2, 1'b1);

    // Reset while WAITing for the engine.
    req_reg_in[4:0] = 5'd3;
    req_valid_in = 2'b01;
    wait_grant("rstw");
    chk("rstw_b0", 32'(spi_byte0_out), 32'h18);
    req_valid_in = 2'b00;
    @(negedge clk_in);
    n_rst_in = 1'b0;
    #1;
    chk("rstw_ready",  32'(req_ready_out),  32'd0);
    chk("rstw_rvld",   32'(rsp_valid_out),  32'd0);
    chk("rstw_svld",   32'(spi_valid_out),  32'd0);
    chk("rstw_status", 32'(rsp_status_out), 32'd0);
    chk("rstw_data",   32'(rsp_data_out),   32'd0);
    chk("rstw_b0z",    32'(spi_byte0_out),  32'd0);
    chk("rstw_b1z",    32'(spi_byte1_out),  32'd0);
    @(negedge clk_in);
    n_rst_in = 1'b1;
    req_reg_in[4:0] = 5'd18;
    @(negedge clk_in);
    req_valid_in = 2'b01;
    run_txn("post_rst", 2'b01, 8'h90, 8'h00, 8'h41, 8'h0C, 2, 1'b1);

`ifdef MAX3421_ARB_TIMEOUT_EN
    begin
      int n;
      req_valid_in = 2'b10;
      req_write_in = 2'b00;
      wait_grant("to");
      chk("to_gnt", 32'(req_ready_out), 32'b10);
      chk("to_b0",  32'(spi_byte0_out), 32'h88);
      req_valid_in = 2'b00;
      n = 0;
      while (rsp_valid_out == 2'b00 && n < 40) begin
        @(negedge clk_in);
        n++;
      end
      chk("to_latency", 32'(n),              32'd17);
      chk("to_rvld",    32'(rsp_valid_out),  32'b10);
      chk("to_err",     32'(rsp_err_out),    32'd1);
      chk("to_status",  32'(rsp_status_out), 32'hFF);
      chk("to_data",    32'(rsp_data_out),   32'hFF);
      req_valid_in = 2'b01;
      run_txn("post_to", 2'b01, 8'h90, 8'h00, 8'h43, 8'h0E, 1, 1'b1);
    end
`endif

    repeat (2) @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
